// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU in the EX stage.
// Produces one quotient bit per clock; one divide in flight at a time.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   signed_div_i    1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i       dividend, sampled together with start_i
//   opdata2_i       divisor, sampled together with start_i
//   start_i         request; held high by EX until ready_o is seen
//   annul_i         pipeline flush; aborts any operation and overrides start_i
//   result_o        {remainder, quotient}; zero whenever ready_o is low
//   dz_o            divide-by-zero flag (present only with DIV_ZERO_FLAG_EN)
//   ready_o         result valid; held while start_i stays high
//
// Build option: define DIV_ZERO_FLAG_EN to add the dz_o port.
module div_unit #(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic            dz_o,
`endif
    output logic            ready_o
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, DIVZ, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic            sign1_q, sign1_d;
    logic            sign2_q, sign2_d;
    logic [2*DW-1:0] result_q, result_d;
    logic            ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic            dz_q, dz_d;
`endif

    // Operand magnitudes; the most-negative value maps onto itself, which
    // is exactly its unsigned magnitude.
    logic            neg1_c, neg2_c;
    logic [DW-1:0]   abs1_c, abs2_c;
    assign neg1_c = signed_div_i & opdata1_i[DW-1];
    assign neg2_c = signed_div_i & opdata2_i[DW-1];
    assign abs1_c = neg1_c ? (~opdata1_i + DW'(1)) : opdata1_i;
    assign abs2_c = neg2_c ? (~opdata2_i + DW'(1)) : opdata2_i;

    // One restoring step; the shifted remainder needs DW+1 bits because
    // the divisor may use the full unsigned range.
    logic [DW:0]     rem_sh_c;
    logic            qbit_c;
    logic [DW-1:0]   rem_nx_c, quo_nx_c, rem_fix_c, quo_fix_c;
    assign rem_sh_c  = {rem_q, dvd_q[DW-1]};
    assign qbit_c    = (rem_sh_c >= {1'b0, dvs_q});
    assign rem_nx_c  = qbit_c ? (rem_sh_c[DW-1:0] - dvs_q) : rem_sh_c[DW-1:0];
    assign quo_nx_c  = {dvd_q[DW-2:0], qbit_c};
    assign quo_fix_c = (sign1_q ^ sign2_q) ? (~quo_nx_c + DW'(1)) : quo_nx_c;
    assign rem_fix_c = sign1_q ? (~rem_nx_c + DW'(1)) : rem_nx_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i && !annul_i)
                      state_d = (opdata2_i == '0) ? DIVZ : BUSY;
            BUSY: if (annul_i)                     state_d = IDLE;
                  else if (cnt_q == CW'(DW - 1))   state_d = DONE;
            DIVZ: state_d = annul_i ? IDLE : DONE;
            DONE: if (annul_i || !start_i)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                dz_d     = 1'b0;
`endif
                if (start_i && !annul_i) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = abs1_c;
                    dvs_d   = abs2_c;
                    sign1_d = neg1_c;
                    sign2_d = neg2_c;
                end
            end
            BUSY: begin
                if (!annul_i) begin
                    rem_d = rem_nx_c;
                    dvd_d = quo_nx_c;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        cnt_d    = '0;
                        result_d = {rem_fix_c, quo_fix_c};
                        ready_d  = 1'b1;
                    end
                end
            end
            DIVZ: begin
                if (!annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d     = 1'b1;
`endif
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d     = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign dz_o     = dz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit with a result scoreboard.
module tb_div_unit;

    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            signed_div_i;
    logic [DW-1:0]   opdata1_i;
    logic [DW-1:0]   opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*DW-1:0] result_o;
    logic            ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic            dz_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [2*DW-1:0] sb_q[$];

    div_unit #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
`ifdef DIV_ZERO_FLAG_EN
        .dz_o         (dz_o),
`endif
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result from magnitudes and the language's own / and %.
    function automatic logic [2*DW-1:0] model(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic na, nb;
        logic [DW-1:0] ma, mb, q, r;
        if (b == '0) return '0;
        na = s & a[DW-1];
        nb = s & b[DW-1];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r, q};
    endfunction

    // Launch one operation, wait for ready_o, compare, hold, release.
    task automatic run_op(input string tag, input logic s, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [2*DW-1:0] exp);
        int cycles;
        int lat;
        logic [2*DW-1:0] e;
        lat = (b == '0) ? 1 : int'(DW);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~s;
        cycles = 0;
        if (ready_o !== 1'b1) begin
            do begin
                @(posedge clk); #1;
                cycles++;
            end while (ready_o !== 1'b1 && cycles < 100);
        end
        check({tag, "_lat"}, 64'(cycles), 64'(lat - ((b == '0) ? 0 : 0)));
        e = sb_q.pop_front();
        check({tag, "_res"}, result_o, e);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_dz"}, 64'(dz_o), 64'(b == '0));
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {result_o[2*DW-2:0], ready_o}, {e[2*DW-2:0], 1'b1});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop"}, {result_o[2*DW-2:0], ready_o}, '0);
    endtask

    task automatic watch_idle(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0 || result_o !== '0) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        logic          rs;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {result_o[2*DW-2:0], ready_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7",  1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("div_m100_7",  1'b1, -32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});
        run_op("div_100_m7",  1'b1, 32'd100, -32'sd7, {32'd2, 32'hFFFFFFF2});
        run_op("div_minneg",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        run_op("divu_max_1",  1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
        run_op("divu_by0",    1'b0, 32'h12345678, 32'd0, '0);
        run_op("div_by0",     1'b1, 32'h80000001, 32'd0, '0);
        run_op("divu_small_big", 1'b0, 32'd5, 32'hFFFFFFFF, {32'd5, 32'd0});

        // Abort at cycle 10 of BUSY: no result may ever appear.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_next", {result_o[2*DW-2:0], ready_o}, '0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        watch_idle("annul_quiet", 40);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // start and annul together in IDLE must not launch anything.
        @(negedge clk);
        opdata1_i = 32'd7; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
        watch_idle("start_annul", 4);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;

        // Reset at cycle 5 of BUSY.
        @(negedge clk);
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", {result_o[2*DW-2:0], ready_o}, '0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        watch_idle("rst_quiet", 40);

        // Random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 2) ? 32'd0 : $urandom >> (i * 4);
            rs = i[0];
            run_op("rand", rs, ra, rb, model(rs, ra, rb));
        end

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
